mem_bus_initiator: RTL and testbench
====================================

MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

Interface
REQ-001 SHALL: parameter TIMEOUT_CYCLES, default 16, is the maximum number of cycles mem_valid stays high awaiting mem_ready (legal range 2..255).
REQ-002 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL: req_valid  input  1  client request present.
REQ-005 SHALL: req_ready  output  1  initiator can accept a request.
REQ-006 SHALL: req_addr  input  32  byte address.
REQ-007 SHALL: req_wdata  input  32  write data.
REQ-008 SHALL: req_write  input  1  1 = word write, 0 = word read.
REQ-009 SHALL: rsp_valid  output  1  response present.
REQ-010 SHALL: rsp_ready  input  1  client accepts the response.
REQ-011 SHALL: rsp_rdata  output  32  read data (0 for writes and errors).
REQ-012 SHALL: rsp_error  output  1  1 = timeout or misaligned address.
REQ-013 SHALL: mem_valid  output  1  bus request to memory responder.
REQ-014 SHALL: mem_ready  input  1  responder completion.
REQ-015 SHALL: mem_addr  output  32  bus address.
REQ-016 SHALL: mem_wdata  output  32  bus write data.
REQ-017 SHALL: mem_wstrb  output  4  4'b1111 write, 4'b0000 read.
REQ-018 SHALL: mem_rdata  input  32  responder read data.
REQ-019 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL: three states: IDLE, BUS (mem_valid asserted), RSP (rsp_valid asserted).
REQ-021 SHALL: req_ready = 1 exactly when state is IDLE (combinational from state); requests are accepted only on req_valid && req_ready at a rising edge.
REQ-022 SHALL: aligned request accepted at edge N: addr/wdata/wstrb registered, state -> BUS, mem_valid = 1 from cycle N+1.
REQ-023 SHALL: request with req_addr[1:0] != 0 at acceptance: no bus access, state -> RSP with rsp_error = 1, rsp_rdata = 0, rsp_valid from cycle N+1.
REQ-024 SHALL: mem_addr, mem_wdata, mem_wstrb held constant while mem_valid = 1; in IDLE mem_wstrb = 4'b0000, mem_addr/mem_wdata hold last value.
REQ-025 SHALL: in BUS, mem_ready = 1 sampled at edge M: mem_valid = 0 from M+1, rsp_rdata <= mem_rdata (read) or 0 (write), rsp_error <= 0, state -> RSP.
REQ-026 SHALL: 8-bit wait counter cleared on entry to BUS, incremented each BUS cycle with mem_ready = 0.
REQ-027 SHALL: in BUS, counter == TIMEOUT_CYCLES-1 and mem_ready = 0 at an edge: mem_valid dropped, rsp_error <= 1, rsp_rdata <= 0, state -> RSP; mem_valid therefore high exactly TIMEOUT_CYCLES cycles.
REQ-028 SHALL: mem_ready = 1 on the final timeout cycle wins: normal completion, no error.
REQ-029 SHALL: mem_ready outside BUS ignored; no state, data or error change.
REQ-030 SHALL: in RSP, rsp_valid, rsp_rdata, rsp_error stable until rsp_ready = 1 at an edge; then state -> IDLE, rsp_valid = 0, req_ready = 1 next cycle.
REQ-031 SHALL: one outstanding transaction maximum; minimum initiation interval 3 cycles (accept, BUS, RSP handshake).

Reset
REQ-032 SHALL: reset_n low asynchronously forces state IDLE, mem_valid 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, counter 0, busy 0.
REQ-033 SHALL: reset asserted mid-BUS or mid-RSP abandons the transaction without any response; first request after release behaves per REQ-022.

Verification
REQ-034 SHALL: read 0x0000_0010, responder asserts mem_ready 3 cycles after mem_valid with mem_rdata 0xDEAD_BEEF -> mem_wstrb 0000, mem_valid high 3 cycles, rsp_rdata 0xDEAD_BEEF, rsp_error 0.
REQ-035 SHALL: write 0x1234_5678 to 0x0000_0080, then read 0x0000_0080 -> write mem_wstrb 1111 with stable addr/wdata; read returns 0x1234_5678, error 0 both.
REQ-036 SHALL: read 0x0000_0020 with mem_ready held 0, TIMEOUT_CYCLES=16 -> mem_valid high exactly 16 cycles, rsp_error 1, rsp_rdata 0; mem_ready on cycle 16 instead -> error 0.
REQ-037 SHALL: read 0x0000_0006 -> mem_valid never asserted, rsp_valid next cycle, rsp_error 1.
REQ-038 SHALL: rsp_ready held 0 for 5 cycles after rsp_valid -> response stable, req_ready 0, spurious mem_ready ignored; completes on rsp_ready.
REQ-039 SHALL: reset_n pulsed low mid-BUS -> outputs to reset values immediately, no rsp_valid; next read completes normally.

Source files
------------

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: single-outstanding word initiator bridging a client
// request/response handshake onto a simple valid/ready memory bus.
// Misaligned requests are answered with an error and never reach the bus;
// a bus access that sees no mem_ready for TIMEOUT_CYCLES cycles is abandoned
// and answered with an error. The file also holds a small protocol checker
// that the top instantiates; it contains only assertions and no logic.

module mem_bus_initiator_chk (
    input logic        clk,
    input logic        reset_n,
    input logic        req_ready,
    input logic        busy,
    input logic        mem_valid,
    input logic [31:0] mem_addr,
    input logic [31:0] mem_wdata,
    input logic [3:0]  mem_wstrb,
    input logic        rsp_valid,
    input logic        rsp_ready,
    input logic [31:0] rsp_rdata,
    input logic        rsp_error
);

    // The initiator accepts requests only while it is not busy.
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset_n)
        req_ready == !busy);

    // A bus access and a pending response never overlap.
    a_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_valid && rsp_valid));

    // Bus address, data and strobes are frozen for the whole access.
    a_bus_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_valid && $past(mem_valid)) |->
            ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_wstrb)));

    // A response that has not been taken keeps its payload.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (rsp_valid && $past(rsp_valid) && !$past(rsp_ready)) |->
            ($stable(rsp_rdata) && $stable(rsp_error)));

    // Strobes are zero whenever the initiator is idle.
    a_idle_wstrb: assert property (@(posedge clk) disable iff (!reset_n)
        !busy |-> (mem_wstrb == 4'b0000));

endmodule

module mem_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RSP  = 2'b10
    } state_t;

    // Last value of the wait counter before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_is_write;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;

    logic        w_misaligned;
    logic        w_accept;
    logic        w_timeout;

    assign w_misaligned = (req_addr[1:0] != 2'b00);
    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_timeout    = (r_wait_cnt == CNT_LAST);

    // Request acceptance, bus access with timeout, and response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 8'd0;
            r_is_write  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'b0000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_misaligned) begin
                            // Answered locally; the bus is never touched.
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                            r_state     <= ST_RSP;
                        end else begin
                            r_mem_addr  <= req_addr;
                            r_mem_wdata <= req_wdata;
                            r_mem_wstrb <= req_write ? 4'b1111 : 4'b0000;
                            r_is_write  <= req_write;
                            r_mem_valid <= 1'b1;
                            r_wait_cnt  <= 8'd0;
                            r_state     <= ST_BUS;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        // Completion takes priority over a same-cycle timeout.
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= r_is_write ? 32'd0 : mem_rdata;
                        r_state     <= ST_RSP;
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= 4'b0000;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_state     <= ST_RSP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_RSP;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    r_state     <= ST_IDLE;
                    r_mem_valid <= 1'b0;
                    r_mem_wstrb <= 4'b0000;
                    r_rsp_valid <= 1'b0;
                    r_wait_cnt  <= 8'd0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

    mem_bus_initiator_chk u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_ready (req_ready),
        .busy      (busy),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Randomized self-checking bench for mem_bus_initiator. A responder model
// answers bus accesses after a chosen delay from a word memory; expected
// responses come from the transaction rules (alignment, delay vs timeout).

module tb_mem_bus_initiator;

    localparam int T = 16;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_total;
    int n_bad;

    logic [31:0] mem_model [logic [31:0]];

    mem_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // One transaction: dly = cycle of mem_valid on which the responder
    // raises mem_ready (> T means never); stall = cycles rsp_ready held low.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] wd,
                          input logic wr, input int dly, input int stall);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_vc;
        int          vc;
        int          st;
        bit          got;
        bit          released;
        bit          done;
        if (a[1:0] != 2'b00) begin
            e_err = 1'b1; e_rd = 32'd0; e_vc = 0;
        end else if (dly <= T) begin
            e_err = 1'b0; e_rd = wr ? 32'd0 : rd(a); e_vc = dly;
        end else begin
            e_err = 1'b1; e_rd = 32'd0; e_vc = T;
        end
        @(negedge clk);
        check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_write = wr;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom_range(0, 1));
        vc = 0; st = 0; got = 0; released = 0; done = 0;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            if (released) begin
                check_eq("rsp_drop", {31'd0, rsp_valid}, 32'd0);
                check_eq("ready_back", {31'd0, req_ready}, 32'd1);
                rsp_ready = 1'b0;
                done = 1;
            end else if (mem_valid) begin
                vc++;
                check_eq("bus_addr", mem_addr, a);
                check_eq("bus_wdata", mem_wdata, wd);
                check_eq("bus_wstrb", {28'd0, mem_wstrb}, wr ? 32'hF : 32'h0);
                if (vc == dly) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd(a);
                    if (wr) mem_model[a] = wd;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                if (rsp_valid) begin
                    if (!got) begin
                        got = 1;
                        check_eq("rsp_latency", cyc, e_vc + 1);
                        check_eq("valid_cycles", vc, e_vc);
                    end
                    check_eq("rsp_rdata", rsp_rdata, e_rd);
                    check_eq("rsp_error", {31'd0, rsp_error}, {31'd0, e_err});
                    check_eq("rsp_req_ready", {31'd0, req_ready}, 32'd0);
                    if (st == stall) begin
                        rsp_ready = 1'b1;
                        released  = 1;
                    end else begin
                        rsp_ready = 1'b0;
                    end
                    st++;
                end
            end
        end
        if (!done) check_eq("txn_hang", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          dsel;
        int          dly;
        n_total   = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_write = 1'b0;
        rsp_ready = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        reset_n = 1'b1;

        // Directed cases.
        mem_model[32'h10] = 32'hDEAD_BEEF;
        do_txn(32'h0000_0010, 32'h0BAD_F00D, 1'b0, 3, 0);
        do_txn(32'h0000_0080, 32'h1234_5678, 1'b1, 2, 1);
        do_txn(32'h0000_0080, 32'h0000_0000, 1'b0, 4, 0);
        do_txn(32'h0000_0020, 32'h0000_0000, 1'b0, 255, 0);
        do_txn(32'h0000_0020, 32'h0000_0000, 1'b0, T, 0);
        do_txn(32'h0000_0006, 32'h0000_0000, 1'b0, 1, 0);
        do_txn(32'h0000_0084, 32'hCAFE_0001, 1'b0, 2, 5);
        do_txn(32'h0000_0088, 32'hAAAA_5555, 1'b1, T + 1, 2);
        do_txn(32'h0000_0088, 32'h0000_0000, 1'b0, 1, 0);
        do_txn(32'h0000_0003, 32'h7777_7777, 1'b1, 1, 3);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            a = {24'd0, r[5:0], 2'b00};
            if (r[31:29] == 3'b000) a[1:0] = r[9:8] | 2'b01;
            dsel = $urandom_range(0, 9);
            case (dsel)
                6:       dly = T - 1;
                7:       dly = T;
                8:       dly = T + 1;
                9:       dly = 200;
                default: dly = dsel + 1;
            endcase
            do_txn(a, $urandom, r[12], dly, $urandom_range(0, 5));
        end

        // Reset in the middle of a bus access.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'h0;
        req_write = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_eq("mid_rst_addr", mem_addr, 32'd0);
        check_eq("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            check_eq("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
            check_eq("post_rst_valid", {31'd0, mem_valid}, 32'd0);
        end
        do_txn(32'h0000_0040, 32'h0, 1'b0, 2, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
